instr_encoder: RTL

- Converts decoded instruction fields (opcode, registers, immediate, shift, flags) back into 32-bit instruction words.
- Streams the encoded words into instruction memory, one write per accepted input, at consecutive word addresses.
- Serves as the program-load path for the core's instruction store; the encoding is the exact inverse of the core's field decode.
- Rejects fields that cannot be encoded and reports the first failing address.

---
 rtl/instr_encoder.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and streams them into
// instruction memory at consecutive addresses, stopping on the last word or an encode error.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [5:0]        opcode,
    input  logic [3:0]        rd,
    input  logic [3:0]        rn,
    input  logic [3:0]        rm,
    input  logic [31:0]       imm_ext,
    input  logic              i,
    input  logic              s,
    input  logic              sh,
    input  logic [4:0]        sh_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX    = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic [31:0]         enc_word;
    logic                legal;

    // Immediate form only carries 16 bits, so bits [31:15] must be a pure sign extension.
    assign legal    = !i || (&imm_ext[31:15]) || !(|imm_ext[31:15]);
    assign enc_word = i ? {opcode, i, s, rd, rn, imm_ext[15:0]}
                        : {opcode, i, s, rd, rn, rm, sh, sh_imm, 6'b000000};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        err_addr_d = err_addr_q;
        we_d       = 1'b0;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = FIRST_ADDR;
                    count_d = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        maddr_d = addr_q;
                        wdata_d = enc_word;
                        addr_d  = addr_q + 1'b1;
                        if (count_q != CNT_MAX) count_d = count_q + 1'b1;
                        // Leaving RUN at acceptance drops in_ready while the final write is issued.
                        if (in_last || addr_q == LAST_ADDR) state_d = DONE;
                    end else begin
                        err_addr_d = addr_q;
                        state_d    = ERR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            err_addr_q <= '0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            err_addr_q <= err_addr_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign err_addr  = err_addr_q;
    assign count     = count_q;

endmodule
